// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU share scheduler: FSM states, ALU opcode
// constants and opcode classification helpers.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_SRL     = 4'b0010;
  localparam logic [3:0] OP_SLL     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_XOR     = 4'b0101;
  localparam logic [3:0] OP_OR      = 4'b0110;
  localparam logic [3:0] OP_SRA     = 4'b1010;
  localparam logic [2:0] OP_MUL_PFX = 3'b111;

  // Multiply opcodes share a 3-bit prefix; the LSB selects the SC variant.
  function automatic logic is_mul(input logic [3:0] op);
    return op[3:1] == OP_MUL_PFX;
  endfunction

  // Opcodes the ALU defines.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_SRL, OP_SLL,
      OP_AND, OP_XOR, OP_OR, OP_SRA: legal = 1'b1;
      default:                       legal = is_mul(op);
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above ptr, wrapping around. The pointer itself is owned by the parent.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : encoded grant index
//   grant_vld : any request granted
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_vld
);

  int unsigned            cand;
  logic [ID_WIDTH-1:0]    cand_idx;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand     = (32'(ptr) + off) % NUM_REQ;
      cand_idx = ID_WIDTH'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Time-shares one PE ALU between NUM_REQ requesters. A round-robin winner's
// opcode/operands are latched and driven onto the ALU; multiply opcodes are
// held for MUL_CYCLES so the stochastic stream settles, other ops for one
// cycle. The result returns with the requester ID on a valid/ready channel.
//
// Optional feature macro: ALU_SCHED_OP_CHECK_EN
//   Adds io_resp_err; illegal opcodes bypass the ALU and return data 0, err 1.
//
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   io_req_valid/ready: per-requester handshake (ready one-hot, IDLE only)
//   io_req_op/a/b     : packed per-requester opcode and operands
//   io_alu_en/a/b/cfg : drive to the shared ALU
//   io_alu_result     : combinational ALU output
//   io_resp_*         : result channel (valid/ready, data, requester id)
//   io_busy           : scheduler not idle
module alu_share_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            io_req_valid,
  output logic [NUM_REQ-1:0]            io_req_ready,
  input  logic [4*NUM_REQ-1:0]          io_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] io_req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] io_req_b,
  output logic                          io_alu_en,
  output logic [DATA_WIDTH-1:0]         io_alu_a,
  output logic [DATA_WIDTH-1:0]         io_alu_b,
  output logic [3:0]                    io_alu_cfg,
  input  logic [OUT_WIDTH-1:0]          io_alu_result,
  output logic                          io_resp_valid,
  input  logic                          io_resp_ready,
  output logic [OUT_WIDTH-1:0]          io_resp_data,
  output logic [ID_WIDTH-1:0]           io_resp_id,
`ifdef ALU_SCHED_OP_CHECK_EN
  output logic                          io_resp_err,
`endif
  output logic                          io_busy
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    alu_en_d;
  logic [DATA_WIDTH-1:0]   alu_a_d, alu_b_d;
  logic [3:0]              alu_cfg_d;
  logic                    resp_valid_d;
  logic [OUT_WIDTH-1:0]    resp_data_d;
  logic [ID_WIDTH-1:0]     resp_id_d;
  logic                    busy_d;
  logic                    capture;
`ifdef ALU_SCHED_OP_CHECK_EN
  logic                    resp_err_d;
`endif

  logic [NUM_REQ-1:0]      gnt;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic                    gnt_vld;
  logic [3:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (io_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  // Winning requester's payload.
  assign sel_op = io_req_op[4*gnt_idx +: 4];
  assign sel_a  = io_req_a[DATA_WIDTH*gnt_idx +: DATA_WIDTH];
  assign sel_b  = io_req_b[DATA_WIDTH*gnt_idx +: DATA_WIDTH];

  // Next-state and output decode. The io_alu_* registers double as the
  // operation latch, so they hold the request for the whole execute phase.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    alu_en_d     = io_alu_en;
    alu_a_d      = io_alu_a;
    alu_b_d      = io_alu_b;
    alu_cfg_d    = io_alu_cfg;
    resp_valid_d = io_resp_valid;
    resp_data_d  = io_resp_data;
    resp_id_d    = io_resp_id;
    io_req_ready = '0;
    capture      = 1'b0;
`ifdef ALU_SCHED_OP_CHECK_EN
    resp_err_d   = io_resp_err;
`endif

    case (state_q)
      IDLE: begin
        io_req_ready = gnt;
        if (gnt_vld) begin
          rr_ptr_d  = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
          resp_id_d = gnt_idx;
`ifdef ALU_SCHED_OP_CHECK_EN
          if (!is_legal_op(sel_op)) begin
            // Illegal opcode never reaches the ALU.
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else
`endif
          begin
            alu_en_d  = 1'b1;
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_cfg_d = sel_op;
            state_d   = EXEC;
          end
        end
      end

      EXEC: begin
        if (is_mul(io_alu_cfg) && (MUL_CYCLES > 1)) begin
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = MUL_WAIT;
        end else begin
          capture = 1'b1;
        end
      end

      // EXEC plus MUL_CYCLES-1 wait cycles gives exactly MUL_CYCLES enabled.
      MUL_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (io_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Sample the ALU on its last enabled cycle and release its inputs.
    if (capture) begin
      resp_valid_d = 1'b1;
      resp_data_d  = io_alu_result;
      alu_en_d     = 1'b0;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_cfg_d    = '0;
      state_d      = RESP;
`ifdef ALU_SCHED_OP_CHECK_EN
      resp_err_d   = 1'b0;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      io_alu_en     <= 1'b0;
      io_alu_a      <= '0;
      io_alu_b      <= '0;
      io_alu_cfg    <= '0;
      io_resp_valid <= 1'b0;
      io_resp_data  <= '0;
      io_resp_id    <= '0;
      io_busy       <= 1'b0;
`ifdef ALU_SCHED_OP_CHECK_EN
      io_resp_err   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      io_alu_en     <= alu_en_d;
      io_alu_a      <= alu_a_d;
      io_alu_b      <= alu_b_d;
      io_alu_cfg    <= alu_cfg_d;
      io_resp_valid <= resp_valid_d;
      io_resp_data  <= resp_data_d;
      io_resp_id    <= resp_id_d;
      io_busy       <= busy_d;
`ifdef ALU_SCHED_OP_CHECK_EN
      io_resp_err   <= resp_err_d;
`endif
    end
  end

endmodule
